pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage of the 32-bit MIPS processor. Holds the architectural PC, drives the instruction-memory request handshake and selects the next PC. Next-PC sources: sequential (PC+4), branch, jump and jump-register. Its pc_plus4 output feeds the jump-address box. The jump box's 32-bit result returns on jump_target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from control; holds PC at the update point
branch_taken  input  1  conditional branch resolved taken for the current instruction
branch_offset  input  32  sign-extended immediate, word offset
jump  input  1  J/JAL instruction at current PC
jump_target  input  32  assembled jump address from the jump box
jr  input  1  JR instruction at current PC
jr_target  input  32  register-file rs value
halt  input  1  halt request, sampled at the update point
imem_ack  input  1  instruction memory accepts and returns data this cycle
pc  output  32  current PC (registered)
pc_plus4  output  32  pc + 4, combinational, mod 2^32
imem_req  output  1  fetch request
imem_addr  output  32  fetch address; equals pc
instr_valid  output  1  one-cycle pulse, registered, the cycle after each accepted ack
misaligned  output  1  sticky flag: a selected next PC had bits [1:0] != 0

Behaviour:
- Reset (async, any cycle, including mid-fetch or in HOLD):
  - pc=RESET_PC, state=RST_WAIT.
  - imem_req=0, instr_valid=0, misaligned=0.
  - Any outstanding ack is discarded.
- States and transitions:
  - RST_WAIT: one cycle with req=0, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Req is held until imem_ack. Ack in any other state is ignored.
  - On ack in FETCH:
    - instr_valid=1 on the next cycle.
    - If halt=1: go to HALTED; PC unchanged (halt has priority over stall and redirects).
    - Else if stall=1: go to HOLD; PC unchanged.
    - Else: update event; remain in FETCH.
  - HOLD: req=0. While stall=1, remain in HOLD. On the first cycle with stall=0: update event, then go to FETCH.
  - HALTED: req=0, PC frozen. Exit only through reset.
- Update event, next-PC priority (highest first):
  1. jr: jr_target
  2. jump: jump_target
  3. branch_taken: pc_plus4 + (branch_offset << 2)
  4. otherwise: pc_plus4
  - All addition is 32-bit and wraps mod 2^32 with no overflow flag.
- Misalignment: if the selected next PC has [1:0] != 0 at an update event:
  - misaligned=1 (sticky), state goes to HALTED, PC not updated.
- Control inputs (jr, jump, branch_taken, branch_offset, targets) are sampled only at update events and are don't-care otherwise.
- Wrap: pc=32'hFFFF_FFFC with sequential flow gives next pc=32'h0000_0000.
- Latency: minimum 1 cycle per instruction (ack in the same cycle as req). Each extra wait cycle adds 1.

Test Plan:
- Reset, then ack every cycle, no controls -> first req 1 cycle after reset release; pc sequence 0x0,0x4,0x8,0xC; instr_valid pulses each cycle after ack.
- pc=0x0040_0010, branch_taken=1, offset=32'hFFFF_FFFC at ack -> pc=0x0040_0004. With offset=3 -> pc=0x0040_0020.
- jump=1, jump_target=0x0000_0100 and branch_taken=1 together -> pc=0x100. Add jr=1, jr_target=0x200 -> pc=0x200.
- Ack with stall=1 for 3 cycles -> req low and pc held for 3 cycles. Update on the first cycle stall=0, then req high next cycle. Ack delayed 2 cycles -> req and addr held stable.
- jr_target=0x0000_0102 -> misaligned=1, pc unchanged, req stays 0. Halt at ack -> HALTED, pc frozen.
- Reset asserted mid-FETCH and in HALTED -> pc=RESET_PC immediately; misaligned and instr_valid cleared asynchronously; sequence restarts. pc=0xFFFF_FFFC sequential -> 0x0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: owns the architectural PC,
// runs the imem request handshake and picks the next PC (seq/branch/jump/jr).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {RST_WAIT, FETCH, HOLD, HALTED} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        vld_q;
  logic        mis_q;
  logic [31:0] npc_d;
  logic        upd;

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = vld_q;
  assign misaligned  = mis_q;

  // An update fires on an unstalled, non-halting ack, or when a HOLD releases.
  assign upd = ((state_q == FETCH) && imem_ack && !halt && !stall) ||
               ((state_q == HOLD) && !stall);

  always_comb begin
    npc_d = pc_plus4;
    if (jr)                npc_d = jr_target;
    else if (jump)         npc_d = jump_target;
    else if (branch_taken) npc_d = pc_plus4 + (branch_offset << 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_WAIT;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      vld_q <= (state_q == FETCH) && imem_ack;
      case (state_q)
        RST_WAIT: state_q <= FETCH;
        FETCH: begin
          if (imem_ack && halt)       state_q <= HALTED;
          else if (imem_ack && stall) state_q <= HOLD;
        end
        default: ;
      endcase
      // A misaligned target freezes the PC and parks the unit until reset.
      if (upd) begin
        if (npc_d[1:0] != 2'b00) begin
          mis_q   <= 1'b1;
          state_q <= HALTED;
        end else begin
          pc_q    <= npc_d;
          state_q <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table plus reset/halt sequences,
// expected outputs queued at drive time and popped after each clock edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic        halt = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_offset = '0, jump_target = '0, jr_target = '0;
  logic [31:0] pc, pc_plus4, imem_addr;
  logic        imem_req, instr_valid, misaligned;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        ack, stall, halt, jr, jump, br;
    logic [31:0] jrt, jt, off;
    logic [31:0] pc;
    logic        req, vld, mis;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[23];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target), .halt(halt), .imem_ack(imem_ack),
    .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr_valid(instr_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic ack, logic stl, logic hlt, logic j_r, logic jmp,
                              logic br, logic [31:0] jrt, logic [31:0] jt,
                              logic [31:0] off, logic [31:0] epc, logic req,
                              logic vld, logic mis);
    vec_t v;
    v.ack = ack; v.stall = stl; v.halt = hlt; v.jr = j_r; v.jump = jmp; v.br = br;
    v.jrt = jrt; v.jt = jt; v.off = off;
    v.pc = epc; v.req = req; v.vld = vld; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] epc, input logic req,
                         input logic vld, input logic mis);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".addr"}, imem_addr, epc);
    chk({tag, ".pc4"}, pc_plus4, epc + 32'd4);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".vld"}, {31'd0, instr_valid}, {31'd0, vld});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, mis});
  endtask

  // Drive on the falling edge, queue the expectation, compare just after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    imem_ack = v.ack; stall = v.stall; halt = v.halt;
    jr = v.jr; jump = v.jump; branch_taken = v.br;
    jr_target = v.jrt; jump_target = v.jt; branch_offset = v.off;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_mis++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk_out(tag, e.pc, e.req, e.vld, e.mis);
    end
  endtask

  initial begin
    //            ack stl hlt jr jmp br  jrt           jt            off           pc            req vld mis
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 1, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_000C, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h0040_0010, 32'h0,       32'h0040_0010, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0040_0004, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h0040_0010, 32'h0,       32'h0040_0010, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h3,        32'h0040_0020, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 1, 32'h0,        32'h0000_0100, 32'h5,       32'h0000_0100, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 1, 1, 1, 32'h0000_0200, 32'h0000_0100, 32'h5,      32'h0000_0200, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 32'h0000_0300, 32'h0,       32'h0,        32'h0000_0200, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'h0000_0500, 32'h1,       32'h0000_0200, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 1, 1, 0);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 0, 1, 0);
    tbl[14] = mk(1, 1, 0, 0, 1, 0, 32'h0,        32'h0000_0700, 32'h0,       32'h0000_0204, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0204, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h0000_0400, 32'h0,       32'h0000_0400, 1, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0404, 1, 1, 0);
    tbl[18] = mk(1, 0, 0, 0, 1, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1, 1, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 1, 1, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 1, 1, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 0, 32'h0000_0102, 32'h0,       32'h0,        32'h0000_0004, 0, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0, 0, 1);

    // Power-on reset state, then release just after a rising edge.
    @(posedge clk); #1;
    chk_out("por", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset while HALTED with misaligned set and pc non-zero.
    reset = 1'b1; #1;
    chk_out("rst_halted", 32'h0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), "b0");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 0), "b1");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 1, 0), "b2");

    // Reset mid-FETCH while instr_valid is high.
    reset = 1'b1; #1;
    chk_out("rst_fetch", 32'h0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // Ack during the post-reset wait cycle is ignored.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), "c0");
    // Halt beats stall and redirects.
    apply(mk(1, 1, 1, 0, 1, 0, 0, 32'h40, 0, 32'h0, 0, 1, 0), "c1");
    apply(mk(1, 0, 0, 0, 1, 0, 0, 32'h40, 0, 32'h0, 0, 0, 0), "c2");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), "c3");

    if (sb_q.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
